imem_program_loader: RTL and testbench

Boot-time loader sitting directly upstream of the cpu's instruction-initialize port. Accepts a stream of 32-bit words over a valid/ready handshake and converts it into the cpu's initialize / instruction_initialize_address / instruction_initialize_data write sequence. Holds the cpu in reset while loading and releases it when the load completes. Supports address-jump records so sparse programs, such as code at 0..28 plus code at 44, load in one stream.

---
 rtl/imem_program_loader_if.sv | 12 +
 rtl/imem_program_loader.sv | 153 +++++++++++++++
 tb/tb_imem_program_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_program_loader_if.sv
// Word stream into the instruction-memory loader: valid/ready handshake with
// an address-jump qualifier and an end-of-program marker.
interface imem_program_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_set_addr;
    logic        in_last;

    modport master (output in_valid, in_data, in_set_addr, in_last, input in_ready);
    modport slave  (input in_valid, in_data, in_set_addr, in_last, output in_ready);
endinterface

// File: rtl/imem_program_loader.sv
// Boot loader turning a word stream into the cpu instruction-initialize write sequence.
// Optional build macro LOADER_CHECKSUM_EN: the in_last data record is an XOR checksum.
module imem_program_loader #(
    parameter int BASE_ADDR   = 0,
    parameter int HOLD_CYCLES = 2,
    parameter int IMEM_BYTES  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    imem_program_loader_if.slave         in_if,
    output logic                         initialize,
    output logic [31:0]                  instruction_initialize_address,
    output logic [31:0]                  instruction_initialize_data,
    output logic                         cpu_rst,
    output logic                         done,
    output logic                         error,
    output logic [15:0]                  word_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HOLD, S_FINISH, S_RUN, S_ERROR
    } state_t;

    localparam logic [31:0] BASE_W    = 32'(BASE_ADDR);
    localparam logic [31:0] IMEM_W    = 32'(IMEM_BYTES);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        last_q, last_d;
    logic        error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wc_d       = wc_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    state_d = S_LOAD;
                    ptr_d   = BASE_W;
                    wc_d    = 16'd0;
                    error_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = 32'd0;
`endif
                end
            end
            S_LOAD: begin
                if (in_if.in_valid) begin
                    if (in_if.in_set_addr) begin
                        if (in_if.in_data[1:0] != 2'b00 || in_if.in_data >= IMEM_W) begin
                            state_d = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
                        end else if (in_if.in_last) begin
                            // A jump cannot end the program: the checksum record is missing.
                            state_d = S_ERROR;
`endif
                        end else begin
                            ptr_d = in_if.in_data;
                            if (in_if.in_last) state_d = S_FINISH;
                        end
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        if (in_if.in_last) begin
                            state_d = (csum_q == in_if.in_data) ? S_FINISH : S_ERROR;
                        end else
`endif
                        if (ptr_q >= IMEM_W) begin
                            state_d = S_ERROR;
                        end else begin
                            addr_d     = ptr_q;
                            data_d     = in_if.in_data;
                            last_d     = in_if.in_last;
                            hold_cnt_d = 16'd0;
                            state_d    = S_HOLD;
`ifdef LOADER_CHECKSUM_EN
                            csum_d     = csum_q ^ in_if.in_data;
`endif
                        end
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    ptr_d   = ptr_q + 32'd4;
                    wc_d    = wc_q + 16'd1;
                    state_d = last_q ? S_FINISH : S_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 16'd1;
                end
            end
            S_FINISH: state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
        if (state_d == S_ERROR) error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= BASE_W;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            wc_q       <= 16'd0;
            hold_cnt_q <= 16'd0;
            last_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wc_q       <= wc_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // FINISH drops initialize while cpu_rst is still high so the memory leaves init mode first.
    assign initialize                     = (state_q == S_LOAD) || (state_q == S_HOLD);
    assign in_if.in_ready                 = (state_q == S_LOAD);
    assign cpu_rst                        = (state_q != S_RUN);
    assign done                           = (state_q == S_RUN);
    assign error                          = error_q;
    assign word_count                     = wc_q;
    assign instruction_initialize_address = addr_q;
    assign instruction_initialize_data    = data_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader; a negedge observer logs every held bus write.
module tb_imem_program_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        initialize, cpu_rst, done, error;
    logic [31:0] iaddr, idata;
    logic [15:0] word_count;

    imem_program_loader_if bus ();

    imem_program_loader dut (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start),
        .in_if                          (bus),
        .initialize                     (initialize),
        .instruction_initialize_address (iaddr),
        .instruction_initialize_data    (idata),
        .cpu_rst                        (cpu_rst),
        .done                           (done),
        .error                          (error),
        .word_count                     (word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_len[$];
    int          unstable = 0;
    int          cyc = 0;
    int          init_fall_cyc = -1;
    int          rst_fall_cyc = -1;

    // Observer: a write is a run of cycles with initialize=1 and in_ready=0.
    initial begin
        bit prev_hold = 0;
        bit prev_init = 0;
        bit prev_crst = 1;
        bit hold_now;
        forever begin
            @(negedge clk);
            cyc++;
            hold_now = (initialize === 1'b1) && (bus.in_ready === 1'b0);
            if (hold_now && !prev_hold) begin
                wr_addr.push_back(iaddr);
                wr_data.push_back(idata);
                wr_len.push_back(1);
            end else if (hold_now) begin
                wr_len[wr_len.size()-1] += 1;
                if (iaddr !== wr_addr[wr_addr.size()-1] || idata !== wr_data[wr_data.size()-1]) unstable++;
            end
            if (prev_init && initialize === 1'b0) init_fall_cyc = cyc;
            if (prev_crst && cpu_rst === 1'b0) rst_fall_cyc = cyc;
            prev_hold = hold_now;
            prev_init = (initialize === 1'b1);
            prev_crst = (cpu_rst === 1'b1);
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_len.delete();
        unstable = 0;
        init_fall_cyc = -1;
        rst_fall_cyc = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one record and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [31:0] d, input bit sa, input bit last, input bit gap, output bit ok);
        int n = 0;
        ok = 1'b1;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_set_addr = sa; bus.in_last = last;
        @(negedge clk);
        while (bus.in_ready !== 1'b1) begin
            n++;
            if (n > 40) begin ok = 1'b0; break; end
            @(negedge clk);
        end
        if (ok) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0; bus.in_set_addr = 1'b0; bus.in_last = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_set_addr = 1'b0; bus.in_last = 1'b0;
        #2 rst = 1'b0;
        #2;
        tests++; if (initialize !== 1'b0) begin fails++; $display("FAIL reset_init got %b want 0", initialize); end
        tests++; if (iaddr !== 32'd0 || idata !== 32'd0) begin fails++; $display("FAIL reset_bus got %h/%h want 0/0", iaddr, idata); end
        tests++; if (cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_flags got cpu_rst=%b done=%b error=%b want 1 0 0", cpu_rst, done, error); end
        tests++; if (bus.in_ready !== 1'b0 || word_count !== 16'd0) begin fails++; $display("FAIL reset_ready_wc got %b/%0d want 0/0", bus.in_ready, word_count); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        tests++; if (bus.in_ready !== 1'b0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL idle_after_reset got ready=%b cpu_rst=%b want 0 1", bus.in_ready, cpu_rst); end
        $display("[TB] reset checks done");
    endtask

    task automatic test_basic();
        bit ok0, ok1, okd;
        clear_log();
        pulse_start();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL start_latency in_ready got %b want 1", bus.in_ready); end
        send(32'h00022020, 1'b0, 1'b0, 1'b0, ok0);
        send(32'h00844022, 1'b0, 1'b1, 1'b0, ok1);
        wait_done(okd);
        tests++; if (!(ok0 && ok1 && okd)) begin fails++; $display("FAIL basic_timeout got sent=%b%b done=%b want 111", ok0, ok1, okd); end
        tests++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL basic_writes got %0d want 2", wr_addr.size()); end
        else begin
            tests++; if (wr_addr[0] !== 32'd0 || wr_addr[1] !== 32'd4) begin fails++; $display("FAIL basic_addr got %h,%h want 0,4", wr_addr[0], wr_addr[1]); end
            tests++; if (wr_data[0] !== 32'h00022020 || wr_data[1] !== 32'h00844022) begin fails++; $display("FAIL basic_data got %h,%h want 00022020,00844022", wr_data[0], wr_data[1]); end
            tests++; if (wr_len[0] !== 2 || wr_len[1] !== 2 || unstable !== 0) begin fails++; $display("FAIL basic_hold got %0d,%0d unstable=%0d want 2,2,0", wr_len[0], wr_len[1], unstable); end
        end
        tests++; if (rst_fall_cyc - init_fall_cyc !== 1) begin fails++; $display("FAIL basic_init_before_rst got gap %0d want 1", rst_fall_cyc - init_fall_cyc); end
        tests++; if (done !== 1'b1 || word_count !== 16'd2 || cpu_rst !== 1'b0) begin fails++; $display("FAIL basic_run got done=%b wc=%0d cpu_rst=%b want 1 2 0", done, word_count, cpu_rst); end
        $display("[TB] basic load: %0d writes, word_count=%0d", wr_addr.size(), word_count);
    endtask

    task automatic test_sparse();
        bit ok, all_ok, okd;
        int bad = 0;
        all_ok = 1'b1;
        clear_log();
        pulse_start();
        tests++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL sparse_cpu_rst_rise got %b want 1", cpu_rst); end
        for (int i = 0; i < 8; i++) begin
            send(32'h00000100 + 32'(i), 1'b0, 1'b0, 1'b0, ok);
            all_ok &= ok;
        end
        send(32'd44, 1'b1, 1'b0, 1'b0, ok); all_ok &= ok;
        send(32'h00048820, 1'b0, 1'b1, 1'b0, ok); all_ok &= ok;
        wait_done(okd);
        tests++; if (!(all_ok && okd)) begin fails++; $display("FAIL sparse_timeout got sent=%b done=%b want 1 1", all_ok, okd); end
        tests++; if (wr_addr.size() !== 9) begin fails++; $display("FAIL sparse_writes got %0d want 9", wr_addr.size()); end
        else begin
            for (int i = 0; i < 8; i++) if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== 32'h00000100 + 32'(i)) bad++;
            tests++; if (bad !== 0) begin fails++; $display("FAIL sparse_body got %0d bad writes want 0", bad); end
            tests++; if (wr_addr[8] !== 32'd44 || wr_data[8] !== 32'h00048820) begin fails++; $display("FAIL sparse_jump got %h@%0d want 00048820@44", wr_data[8], wr_addr[8]); end
        end
        tests++; if (word_count !== 16'd9) begin fails++; $display("FAIL sparse_wc got %0d want 9", word_count); end
        $display("[TB] sparse load: %0d writes, word_count=%0d", wr_addr.size(), word_count);
    endtask

    task automatic test_backpressure();
        bit ok, all_ok, okd;
        int bad = 0;
        all_ok = 1'b1;
        clear_log();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send(32'hA0000000 + 32'(i), 1'b0, (i == 4), 1'b1, ok);
            all_ok &= ok;
        end
        wait_done(okd);
        tests++; if (!(all_ok && okd)) begin fails++; $display("FAIL bp_timeout got sent=%b done=%b want 1 1", all_ok, okd); end
        tests++; if (wr_addr.size() !== 5) begin fails++; $display("FAIL bp_writes got %0d want 5", wr_addr.size()); end
        else begin
            for (int i = 0; i < 5; i++) if (wr_addr[i] !== 32'(4 * i) || wr_data[i] !== 32'hA0000000 + 32'(i) || wr_len[i] !== 2) bad++;
            tests++; if (bad !== 0 || unstable !== 0) begin fails++; $display("FAIL bp_sequence got bad=%0d unstable=%0d want 0 0", bad, unstable); end
        end
        tests++; if (word_count !== 16'd5) begin fails++; $display("FAIL bp_wc got %0d want 5", word_count); end
        $display("[TB] backpressure load: %0d writes", wr_addr.size());
    endtask

    task automatic test_errors();
        bit ok, okd;
        clear_log();
        pulse_start();
        send(32'h0000002A, 1'b1, 1'b0, 1'b0, ok);
        tests++; if (error !== 1'b1 || cpu_rst !== 1'b1 || initialize !== 1'b0 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL err_unaligned got error=%b cpu_rst=%b init=%b ready=%b want 1 1 0 0", error, cpu_rst, initialize, bus.in_ready); end
        repeat (3) @(posedge clk); #1;
        tests++; if (error !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL err_sticky got error=%b done=%b want 1 0", error, done); end
        pulse_start();
        tests++; if (error !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL err_restart got error=%b ready=%b want 0 1", error, bus.in_ready); end
        clear_log();
        send(32'd1020, 1'b1, 1'b0, 1'b0, ok);
        send(32'h00000011, 1'b0, 1'b0, 1'b0, ok);
        send(32'h00000022, 1'b0, 1'b0, 1'b0, ok);
        tests++; if (error !== 1'b1 || word_count !== 16'd1) begin fails++; $display("FAIL err_overflow got error=%b wc=%0d want 1 1", error, word_count); end
        tests++; if (wr_addr.size() !== 1 || (wr_addr.size() == 1 && wr_addr[0] !== 32'd1020)) begin fails++; $display("FAIL err_overflow_writes got %0d writes want 1 at 1020", wr_addr.size()); end
        pulse_start();
        tests++; if (error !== 1'b0 || word_count !== 16'd0) begin fails++; $display("FAIL err_clear got error=%b wc=%0d want 0 0", error, word_count); end
        clear_log();
        send(32'h00000033, 1'b0, 1'b1, 1'b0, ok);
        wait_done(okd);
        tests++; if (!okd || wr_addr.size() !== 1 || (wr_addr.size() == 1 && wr_addr[0] !== 32'd0)) begin fails++; $display("FAIL err_base_restart got done=%b writes=%0d want 1 1 at 0", okd, wr_addr.size()); end
        $display("[TB] error scenarios done, word_count=%0d", word_count);
    endtask

    task automatic test_reset_midload();
        bit ok;
        pulse_start();
        send(32'h00000001, 1'b0, 1'b0, 1'b0, ok);
        send(32'h00000002, 1'b0, 1'b0, 1'b0, ok);
        send(32'h00000003, 1'b0, 1'b0, 1'b0, ok);
        tests++; if (initialize !== 1'b1 || bus.in_ready !== 1'b0 || iaddr !== 32'd8) begin fails++; $display("FAIL midload_hold got init=%b ready=%b addr=%0d want 1 0 8", initialize, bus.in_ready, iaddr); end
        rst = 1'b0;
        #1;
        tests++; if (initialize !== 1'b0 || iaddr !== 32'd0 || idata !== 32'd0) begin fails++; $display("FAIL midload_bus got init=%b addr=%h data=%h want 0 0 0", initialize, iaddr, idata); end
        tests++; if (cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0 || bus.in_ready !== 1'b0 || word_count !== 16'd0) begin fails++; $display("FAIL midload_flags got cpu_rst=%b done=%b err=%b ready=%b wc=%0d want 1 0 0 0 0", cpu_rst, done, error, bus.in_ready, word_count); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        $display("[TB] reset mid-load done");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        bit ok, okd;
        clear_log();
        pulse_start();
        send(32'h1, 1'b0, 1'b0, 1'b0, ok);
        send(32'h2, 1'b0, 1'b0, 1'b0, ok);
        send(32'h3, 1'b0, 1'b1, 1'b0, ok);
        wait_done(okd);
        tests++; if (!okd || word_count !== 16'd2 || wr_addr.size() !== 2) begin fails++; $display("FAIL csum_match got done=%b wc=%0d writes=%0d want 1 2 2", okd, word_count, wr_addr.size()); end
        pulse_start();
        send(32'h1, 1'b0, 1'b0, 1'b0, ok);
        send(32'h2, 1'b0, 1'b0, 1'b0, ok);
        send(32'h4, 1'b0, 1'b1, 1'b0, ok);
        tests++; if (error !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL csum_mismatch got error=%b done=%b want 1 0", error, done); end
        $display("[TB] checksum checks done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_basic();
        test_sparse();
        test_backpressure();
        test_errors();
        test_reset_midload();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
